mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the ports memRead, memWrite, asByte, asUnsigned, input, 1 bit each: from the EX/MEM register.
REQ-004 The block SHALL have the ports ALU_result and read_data_2, input, 32 bits each: the address and the store data.
REQ-005 The block SHALL have the ports branch, jump, jump_return, zero and lt_zero, input, 1 bit each.
REQ-006 The block SHALL have the port bType, input, 2 bits.
REQ-007 The block SHALL have the port branch_destination, input, 32 bits.
REQ-008 The block SHALL have the ports dmem_req and dmem_we, output, 1 bit each: the data-memory request.
REQ-009 The block SHALL have the ports dmem_addr and dmem_wdata, output, 32 bits each; dmem_addr SHALL be word-aligned.
REQ-010 The block SHALL have the port dmem_be, output, 4 bits: the byte enables.
REQ-011 The block SHALL have the ports dmem_ready (input, 1 bit) and dmem_rdata (input, 32 bits).
REQ-012 The block SHALL have the port read_data, output, 32 bits: the extended load result toward MEM/WB.
REQ-013 The block SHALL have the port stall, output, 1 bit: freezes the PC, IF/ID, ID/EX and EX/MEM.
REQ-014 The block SHALL have the ports take_branch (output, 1 bit) and target_pc (output, 32 bits).
REQ-015 The block SHALL have the ports misaligned and timeout_err, output, 1 bit each: sticky error flags.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT and DONE; access = (memRead|memWrite) & ~misaligned_now, where misaligned_now = ~asByte & (ALU_result[1:0]!=0).
REQ-017 In IDLE with access, dmem_req=1 and stall=1 combinationally in the same cycle; dmem_ready=1 SHALL go to DONE, otherwise WAIT.
REQ-018 In WAIT, dmem_req=1 and stall=1 SHALL hold until dmem_ready=1, then go to DONE.
REQ-019 DONE SHALL last exactly one cycle with stall=0 and dmem_req=0, then go to IDLE; the same EX/MEM instruction SHALL NOT be reissued.
REQ-020 Minimum memory-op cost SHALL be 1 stall cycle (ready in the request cycle).
REQ-021 dmem_we SHALL equal memWrite while dmem_req=1 and SHALL be 0 otherwise.
REQ-022 dmem_addr SHALL be {ALU_result[31:2],2'b00}.
REQ-023 Word access: dmem_be=4'b1111 and dmem_wdata=read_data_2.
REQ-024 Byte access: dmem_be=4'b0001<<ALU_result[1:0] and dmem_wdata={4{read_data_2[7:0]}}.
REQ-025 Load data SHALL be captured into a 32-bit register on the cycle dmem_ready=1 with a read pending.
REQ-026 read_data SHALL present that register during DONE and the following IDLE cycle.
REQ-027 Byte load SHALL select lane ALU_result[1:0], then zero-extend if asUnsigned, else sign-extend bit 7; word loads SHALL pass through.
REQ-028 memRead&memWrite both high SHALL be treated as a write.
REQ-029 A misaligned word access SHALL issue no request and no stall, and SHALL set misaligned.
REQ-030 Timeout: a 4-bit counter SHALL count request cycles without dmem_ready; at 15, the next cycle SHALL set timeout_err, drop dmem_req, load read_data=0 and go to DONE.
REQ-031 The timeout counter SHALL clear on every entry to IDLE.
REQ-032 take_branch = jump | jump_return | (branch & cond), with cond = zero/~zero/lt_zero/~lt_zero for bType 00/01/10/11.
REQ-033 take_branch SHALL be forced 0 while stall=1.
REQ-034 target_pc SHALL equal branch_destination (combinational).

Reset
REQ-035 rst SHALL force, at the next rising edge: state=IDLE, timeout counter=0, load register=0, misaligned=0, timeout_err=0.
REQ-036 After rst, dmem_req, stall and take_branch SHALL be 0 until a new access or branch arrives.
REQ-037 rst asserted in WAIT SHALL abandon the request: dmem_req=0 in the cycle after the edge, and a late dmem_ready SHALL be ignored.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, the bType encodings (BEQ=00, BNE=01, BLT=10, BGE=11), TIMEOUT_MAX=15 and the NOP encoding 32'h00000013.
REQ-039 One sub-module, load_extend (lane select plus sign/zero extension, combinational), is natural; the FSM, counter and branch logic SHALL stay in mem_stage.

Verification
REQ-040 Word load: addr 0x104, dmem_ready in the same cycle, rdata 0xDEADBEEF -> stall exactly 1 cycle, read_data=0xDEADBEEF in DONE, be=1111.
REQ-041 Byte load: addr 0x103, rdata 0x80FF1234, 3 wait cycles -> stall 4 cycles; read_data=0xFFFFFF80 signed, 0x00000080 with asUnsigned.
REQ-042 Byte store: addr 0x22, read_data_2=0x000000A5 -> be=0100, wdata=0xA5A5A5A5, we=1 only while req.
REQ-043 Misaligned word store to 0x101 -> no dmem_req, stall=0, misaligned=1 until rst.
REQ-044 Ready never returns -> req for 16 cycles, then timeout_err=1, read_data=0, FSM back to IDLE.
REQ-045 rst in WAIT -> req=0 the next cycle; BLT with lt_zero=1 while stalled -> take_branch=0, then 1 once stall drops.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, branch
// condition encodings, timeout limit and byte-enable helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [1:0] BEQ = 2'b00;
    localparam logic [1:0] BNE = 2'b01;
    localparam logic [1:0] BLT = 2'b10;
    localparam logic [1:0] BGE = 2'b11;

    localparam logic [3:0]  TIMEOUT_MAX = 4'd15;
    localparam logic [31:0] NOP         = 32'h00000013;

    function automatic logic [3:0] byte_enable(input logic as_byte, input logic [1:0] lane);
        return as_byte ? (4'b0001 << lane) : 4'b1111;
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load lane select plus sign/zero extension; word loads pass straight through.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic        as_byte_i,
    input  logic        as_unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0] lane_byte;

    always_comb begin
        lane_byte = rdata_i[7:0];
        unique case (lane_i)
            2'd0: lane_byte = rdata_i[7:0];
            2'd1: lane_byte = rdata_i[15:8];
            2'd2: lane_byte = rdata_i[23:16];
            2'd3: lane_byte = rdata_i[31:24];
            default: lane_byte = rdata_i[7:0];
        endcase

        if (!as_byte_i) begin
            data_o = rdata_i;
        end else if (as_unsigned_i) begin
            data_o = {24'h000000, lane_byte};
        end else begin
            data_o = {{24{lane_byte[7]}}, lane_byte};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake FSM with timeout, load capture and
// extension, sticky error flags and branch resolution.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        asByte,
    input  logic        asUnsigned,
    input  logic [31:0] ALU_result,
    input  logic [31:0] read_data_2,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_return,
    input  logic        zero,
    input  logic        lt_zero,
    input  logic [1:0]  bType,
    input  logic [31:0] branch_destination,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        take_branch,
    output logic [31:0] target_pc,
    output logic        misaligned,
    output logic        timeout_err
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] load_q, load_d;
    logic        misaligned_q, misaligned_d;
    logic        timeout_q, timeout_d;

    logic        mem_op, misaligned_now, access, read_pending, cond;
    logic [31:0] load_ext;

    assign mem_op         = memRead | memWrite;
    assign misaligned_now = ~asByte & (ALU_result[1:0] != 2'b00);
    assign access         = mem_op & ~misaligned_now;
    assign read_pending   = memRead & ~memWrite;

    // Extension happens at capture: EX/MEM has moved on by the IDLE cycle after DONE.
    load_extend u_load_extend (
        .rdata_i       (dmem_rdata),
        .lane_i        (ALU_result[1:0]),
        .as_byte_i     (asByte),
        .as_unsigned_i (asUnsigned),
        .data_o        (load_ext)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_d       = load_q;
        misaligned_d = misaligned_q;
        timeout_d    = timeout_q;
        dmem_req     = 1'b0;
        stall        = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (access) begin
                    dmem_req = 1'b1;
                    stall    = 1'b1;
                end else if (mem_op) begin
                    misaligned_d = 1'b1;
                end
            end
            StWait: begin
                dmem_req = 1'b1;
                stall    = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
            default: state_d = StIdle;
        endcase

        if (dmem_req) begin
            if (dmem_ready) begin
                state_d = StDone;
                if (read_pending) begin
                    load_d = load_ext;
                end
            end else if (cnt_q == TIMEOUT_MAX) begin
                state_d   = StDone;
                timeout_d = 1'b1;
                load_d    = 32'h0;
            end else begin
                state_d = StWait;
                cnt_d   = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            load_q       <= 32'h0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_q       <= load_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
        end
    end

    assign dmem_we    = dmem_req & memWrite;
    assign dmem_addr  = {ALU_result[31:2], 2'b00};
    assign dmem_be    = byte_enable(asByte, ALU_result[1:0]);
    assign dmem_wdata = asByte ? {4{read_data_2[7:0]}} : read_data_2;
    assign read_data  = load_q;
    assign misaligned  = misaligned_q;
    assign timeout_err = timeout_q;

    always_comb begin
        cond = 1'b0;
        unique case (bType)
            BEQ: cond = zero;
            BNE: cond = ~zero;
            BLT: cond = lt_zero;
            BGE: cond = ~lt_zero;
            default: cond = 1'b0;
        endcase
    end

    assign take_branch = (jump | jump_return | (branch & cond)) & ~stall;
    assign target_pc   = branch_destination;

endmodule
